// File: rtl/gcd_arbiter.sv
// Round-robin front end that shares one subtractive GCD engine among N requesters.
// Zero operands are answered without the engine; a watchdog aborts a stuck engine.
module gcd_arbiter #(
    parameter int N       = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   a_in,
    input  logic [N*W-1:0]   b_in,
    output logic [N-1:0]     ack,
    output logic [N-1:0]     rsp_valid,
    output logic [W-1:0]     rsp_result,
    output logic             rsp_error,
    output logic             busy,
    output logic             eng_start,
    output logic [W-1:0]     eng_a,
    output logic [W-1:0]     eng_b,
    input  logic             eng_done,
    input  logic [W-1:0]     eng_result,
    output logic             eng_clear_n
);

    localparam int IW  = $clog2(N);
    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [IW-1:0]  RR_INIT = IW'(N - 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [N-1:0]   ONE     = N'(1);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, ABORT, RESP} state_t;

    state_t          state;
    logic [IW-1:0]   rr;
    logic [IW-1:0]   gnt;
    logic [WDW-1:0]  wd;

    logic [W-1:0]    a_arr [N];
    logic [W-1:0]    b_arr [N];
    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_arr[i] = a_in[i*W +: W];
            b_arr[i] = b_in[i*W +: W];
        end
    end

    // Search upward from the slot after the last grant, wrapping at N.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(rr) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rr          <= RR_INIT;
            gnt         <= '0;
            wd          <= '0;
            ack         <= '0;
            rsp_valid   <= '0;
            rsp_result  <= '0;
            rsp_error   <= 1'b0;
            busy        <= 1'b0;
            eng_start   <= 1'b0;
            eng_a       <= '0;
            eng_b       <= '0;
            eng_clear_n <= 1'b1;
        end else begin
            ack         <= '0;
            rsp_valid   <= '0;
            eng_start   <= 1'b0;
            eng_clear_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt       <= pick;
                        rr        <= pick;
                        ack       <= ONE << pick;
                        eng_a     <= a_arr[pick];
                        eng_b     <= b_arr[pick];
                        eng_start <= (a_arr[pick] != '0) && (b_arr[pick] != '0);
                        busy      <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // A zero operand would never converge in the engine, so answer here.
                    if (eng_a == '0 || eng_b == '0) begin
                        rsp_result <= (eng_a == '0) ? eng_b : eng_a;
                        rsp_error  <= (eng_a == '0) && (eng_b == '0);
                        rsp_valid  <= ONE << gnt;
                        state      <= RESP;
                    end else begin
                        wd    <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (eng_done) begin
                        rsp_result <= eng_result;
                        rsp_error  <= 1'b0;
                        rsp_valid  <= ONE << gnt;
                        state      <= RESP;
                    end else if (wd == WD_LAST) begin
                        eng_clear_n <= 1'b0;
                        state       <= ABORT;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ABORT: begin
                    rsp_result <= '0;
                    rsp_error  <= 1'b1;
                    rsp_valid  <= ONE << gnt;
                    state      <= RESP;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter: N=4, W=32, TIMEOUT=8, engine driven by hand per scenario.
module tb_gcd_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int TIMEOUT = 8;

    logic             clk;
    logic             reset_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   a_in;
    logic [N*W-1:0]   b_in;
    logic [N-1:0]     ack;
    logic [N-1:0]     rsp_valid;
    logic [W-1:0]     rsp_result;
    logic             rsp_error;
    logic             busy;
    logic             eng_start;
    logic [W-1:0]     eng_a;
    logic [W-1:0]     eng_b;
    logic             eng_done;
    logic [W-1:0]     eng_result;
    logic             eng_clear_n;

    logic [W-1:0]     a_op [N];
    logic [W-1:0]     b_op [N];

    int tests_run;
    int tests_failed;

    gcd_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .a_in(a_in), .b_in(b_in),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
        .busy(busy), .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
        .eng_done(eng_done), .eng_result(eng_result), .eng_clear_n(eng_clear_n)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_in[i*W +: W] = a_op[i];
            b_in[i*W +: W] = b_op[i];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL reset_ack got %b want 0000", ack); end
        tests_run++; if (rsp_valid !== 4'b0000) begin tests_failed++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
        tests_run++; if (rsp_result !== 32'd0) begin tests_failed++; $display("FAIL reset_rsp_result got %0d want 0", rsp_result); end
        tests_run++; if (rsp_error !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_error got %b want 0", rsp_error); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (eng_start !== 1'b0) begin tests_failed++; $display("FAIL reset_eng_start got %b want 0", eng_start); end
        tests_run++; if (eng_a !== 32'd0 || eng_b !== 32'd0) begin tests_failed++; $display("FAIL reset_eng_ops got %0d/%0d want 0/0", eng_a, eng_b); end
        tests_run++; if (eng_clear_n !== 1'b1) begin tests_failed++; $display("FAIL reset_eng_clear_n got %b want 1", eng_clear_n); end
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_single();
        int starts;
        starts = 0;
        a_op[0] = 32'd48; b_op[0] = 32'd18; req = 4'b0001;
        @(negedge clk);
        if (eng_start) starts++;
        tests_run++; if (ack !== 4'b0001) begin tests_failed++; $display("FAIL single_ack got %b want 0001", ack); end
        tests_run++; if (eng_start !== 1'b1) begin tests_failed++; $display("FAIL single_start got %b want 1", eng_start); end
        tests_run++; if (eng_a !== 32'd48 || eng_b !== 32'd18) begin tests_failed++; $display("FAIL single_ops got %0d/%0d want 48/18", eng_a, eng_b); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy got %b want 1", busy); end
        req = 4'b0000;
        a_op[0] = 32'd1;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            if (eng_start) starts++;
            tests_run++; if (rsp_valid !== 4'b0000) begin tests_failed++; $display("FAIL single_early_rsp cycle %0d got %b want 0000", c, rsp_valid); end
        end
        tests_run++; if (eng_a !== 32'd48) begin tests_failed++; $display("FAIL single_ops_held got %0d want 48", eng_a); end
        eng_done = 1'b1; eng_result = 32'd6;
        @(negedge clk);
        if (eng_start) starts++;
        tests_run++; if (rsp_valid !== 4'b0001) begin tests_failed++; $display("FAIL single_rsp_valid got %b want 0001", rsp_valid); end
        tests_run++; if (rsp_result !== 32'd6) begin tests_failed++; $display("FAIL single_result got %0d want 6", rsp_result); end
        tests_run++; if (rsp_error !== 1'b0) begin tests_failed++; $display("FAIL single_error got %b want 0", rsp_error); end
        eng_done = 1'b0;
        @(negedge clk);
        if (eng_start) starts++;
        tests_run++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin tests_failed++; $display("FAIL single_after got rsp_valid=%b busy=%b want 0000/0", rsp_valid, busy); end
        tests_run++; if (starts !== 1) begin tests_failed++; $display("FAIL single_start_count got %0d want 1", starts); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_oh;
        int waited;
        int g;
        reset_n = 1'b0; req = 4'b0000;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin a_op[i] = 32'd0; b_op[i] = 32'(10 + i); end
        reset_n = 1'b1; req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            g = t % 4;
            exp_oh = 4'b0001 << g;
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (ack === 4'b0000 && waited < 8);
            tests_run++; if (ack !== exp_oh) begin tests_failed++; $display("FAIL rr_grant %0d got %b want %b", t, ack, exp_oh); end
            tests_run++; if (rsp_valid !== 4'b0000) begin tests_failed++; $display("FAIL rr_overlap %0d got %b want 0000", t, rsp_valid); end
            @(negedge clk);
            tests_run++; if (rsp_valid !== exp_oh) begin tests_failed++; $display("FAIL rr_rsp %0d got %b want %b", t, rsp_valid, exp_oh); end
            tests_run++; if (rsp_result !== 32'(10 + g)) begin tests_failed++; $display("FAIL rr_result %0d got %0d want %0d", t, rsp_result, 10 + g); end
        end
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_bypass();
        int bi [3];
        logic [W-1:0] ba [3];
        logic [W-1:0] bb [3];
        logic [W-1:0] br [3];
        logic be [3];
        logic [3:0] exp_oh;
        bi = '{3, 2, 1};
        ba = '{32'd0, 32'd0, 32'd21};
        bb = '{32'd0, 32'd35, 32'd0};
        br = '{32'd0, 32'd35, 32'd21};
        be = '{1'b1, 1'b0, 1'b0};
        for (int v = 0; v < 3; v++) begin
            exp_oh = 4'b0001 << bi[v];
            a_op[bi[v]] = ba[v]; b_op[bi[v]] = bb[v]; req = exp_oh;
            @(negedge clk);
            tests_run++; if (ack !== exp_oh || eng_start !== 1'b0) begin tests_failed++; $display("FAIL bypass_ack %0d got ack=%b start=%b want %b/0", v, ack, eng_start, exp_oh); end
            req = 4'b0000;
            @(negedge clk);
            tests_run++; if (rsp_valid !== exp_oh || eng_start !== 1'b0) begin tests_failed++; $display("FAIL bypass_rsp %0d got rsp_valid=%b start=%b want %b/0", v, rsp_valid, eng_start, exp_oh); end
            tests_run++; if (rsp_result !== br[v]) begin tests_failed++; $display("FAIL bypass_result %0d got %0d want %0d", v, rsp_result, br[v]); end
            tests_run++; if (rsp_error !== be[v]) begin tests_failed++; $display("FAIL bypass_error %0d got %b want %b", v, rsp_error, be[v]); end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        a_op[1] = 32'd7; b_op[1] = 32'd5; req = 4'b0010; eng_result = 32'd77;
        @(negedge clk);
        tests_run++; if (ack !== 4'b0010 || eng_start !== 1'b1) begin tests_failed++; $display("FAIL to_ack got ack=%b start=%b want 0010/1", ack, eng_start); end
        req = 4'b0000;
        for (int c = 2; c <= 9; c++) begin
            @(negedge clk);
            tests_run++; if ({eng_clear_n, rsp_valid} !== 5'b10000) begin tests_failed++; $display("FAIL to_wait cycle %0d got clear_n=%b rsp_valid=%b want 1/0000", c, eng_clear_n, rsp_valid); end
        end
        @(negedge clk);
        tests_run++; if (eng_clear_n !== 1'b0 || rsp_valid !== 4'b0000) begin tests_failed++; $display("FAIL to_abort got clear_n=%b rsp_valid=%b want 0/0000", eng_clear_n, rsp_valid); end
        @(negedge clk);
        tests_run++; if (rsp_valid !== 4'b0010 || eng_clear_n !== 1'b1) begin tests_failed++; $display("FAIL to_rsp got rsp_valid=%b clear_n=%b want 0010/1", rsp_valid, eng_clear_n); end
        tests_run++; if (rsp_result !== 32'd0 || rsp_error !== 1'b1) begin tests_failed++; $display("FAIL to_result got %0d err=%b want 0/1", rsp_result, rsp_error); end
        @(negedge clk);

        a_op[2] = 32'd9; b_op[2] = 32'd3; req = 4'b0100;
        @(negedge clk);
        tests_run++; if (ack !== 4'b0100) begin tests_failed++; $display("FAIL tie_ack got %b want 0100", ack); end
        req = 4'b0000;
        for (int c = 2; c <= 9; c++) @(negedge clk);
        eng_done = 1'b1; eng_result = 32'd3;
        @(negedge clk);
        tests_run++; if (rsp_valid !== 4'b0100 || eng_clear_n !== 1'b1) begin tests_failed++; $display("FAIL tie_rsp got rsp_valid=%b clear_n=%b want 0100/1", rsp_valid, eng_clear_n); end
        tests_run++; if (rsp_result !== 32'd3 || rsp_error !== 1'b0) begin tests_failed++; $display("FAIL tie_result got %0d err=%b want 3/0", rsp_result, rsp_error); end
        eng_done = 1'b0;
        @(negedge clk);
        tests_run++; if (eng_clear_n !== 1'b1 || rsp_valid !== 4'b0000) begin tests_failed++; $display("FAIL tie_after got clear_n=%b rsp_valid=%b want 1/0000", eng_clear_n, rsp_valid); end
    endtask

    task automatic test_reset_mid();
        logic rv_seen;
        rv_seen = 1'b0;
        a_op[0] = 32'd9; b_op[0] = 32'd6; req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0 || ack !== 4'b0000 || rsp_valid !== 4'b0000) begin tests_failed++; $display("FAIL mid_ctrl got busy=%b ack=%b rsp_valid=%b want 0/0000/0000", busy, ack, rsp_valid); end
        tests_run++; if (eng_a !== 32'd0 || eng_b !== 32'd0 || eng_start !== 1'b0 || eng_clear_n !== 1'b1) begin tests_failed++; $display("FAIL mid_eng got a=%0d b=%0d start=%b clear_n=%b want 0/0/0/1", eng_a, eng_b, eng_start, eng_clear_n); end
        tests_run++; if (rsp_result !== 32'd0 || rsp_error !== 1'b0) begin tests_failed++; $display("FAIL mid_rsp got %0d err=%b want 0/0", rsp_result, rsp_error); end
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0000) rv_seen = 1'b1;
        end
        a_op[0] = 32'd0; b_op[0] = 32'd40; a_op[3] = 32'd0; b_op[3] = 32'd50;
        req = 4'b1001; reset_n = 1'b1;
        @(negedge clk);
        tests_run++; if (ack !== 4'b0001) begin tests_failed++; $display("FAIL mid_first_grant got %b want 0001", ack); end
        @(negedge clk);
        tests_run++; if (rsp_valid !== 4'b0001 || rsp_result !== 32'd40) begin tests_failed++; $display("FAIL mid_first_rsp got %b/%0d want 0001/40", rsp_valid, rsp_result); end
        @(negedge clk);
        @(negedge clk);
        tests_run++; if (ack !== 4'b1000) begin tests_failed++; $display("FAIL mid_second_grant got %b want 1000", ack); end
        req = 4'b0000;
        @(negedge clk);
        tests_run++; if (rsp_valid !== 4'b1000 || rsp_result !== 32'd50) begin tests_failed++; $display("FAIL mid_second_rsp got %b/%0d want 1000/50", rsp_valid, rsp_result); end
        tests_run++; if (rv_seen !== 1'b0) begin tests_failed++; $display("FAIL mid_no_rsp got %b want 0", rv_seen); end
        @(negedge clk);
    endtask

    task automatic test_stale_done();
        a_op[0] = 32'd12; b_op[0] = 32'd8; req = 4'b0001;
        eng_done = 1'b1; eng_result = 32'd111;
        @(negedge clk);
        tests_run++; if (ack !== 4'b0001 || eng_start !== 1'b1) begin tests_failed++; $display("FAIL stale_ack got ack=%b start=%b want 0001/1", ack, eng_start); end
        req = 4'b0000;
        @(negedge clk);
        eng_done = 1'b0;
        tests_run++; if (rsp_valid !== 4'b0000) begin tests_failed++; $display("FAIL stale_launch got %b want 0000", rsp_valid); end
        @(negedge clk);
        tests_run++; if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin tests_failed++; $display("FAIL stale_wait got rsp_valid=%b busy=%b want 0000/1", rsp_valid, busy); end
        eng_done = 1'b1; eng_result = 32'd4;
        @(negedge clk);
        tests_run++; if (rsp_valid !== 4'b0001 || rsp_result !== 32'd4) begin tests_failed++; $display("FAIL stale_rsp got %b/%0d want 0001/4", rsp_valid, rsp_result); end
        eng_done = 1'b0;
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL stale_idle got busy=%b want 0", busy); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset_n = 1'b0;
        req = '0;
        eng_done = 1'b0;
        eng_result = '0;
        for (int i = 0; i < N; i++) begin a_op[i] = '0; b_op[i] = '0; end
        test_reset();
        test_single();
        test_round_robin();
        test_bypass();
        test_timeout();
        test_reset_mid();
        test_stale_done();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gcd_arbiter.md
# gcd_arbiter

Round-robin arbiter and sequencer that shares one subtract-and-swap GCD engine among N requesters. It captures one requester's operand pair and launches the engine with a one-cycle start pulse. It then waits for the engine's done, guarded by a watchdog, and returns the result to the granted requester. Zero operands, which would stall a subtractive engine, are answered directly without launching it.

## Interface
- N, 4, number of requesters (2..8)
- W, 32, operand/result width
- TIMEOUT, 1024, max WAIT cycles before abort (≥2)

- clk  in  1  clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  N  per-requester request level; held with operands until ack
- a_in  in  N*W  operand a, requester i at bits [i*W +: W]
- b_in  in  N*W  operand b, same packing
- ack  out  N  one-cycle pulse: operands of requester i captured
- rsp_valid  out  N  one-cycle pulse: response for requester i
- rsp_result  out  W  GCD result, valid with rsp_valid
- rsp_error  out  1  valid with rsp_valid: 1 = timeout or both operands zero
- busy  out  1  high in every state except IDLE
- eng_start  out  1  one-cycle engine start pulse
- eng_a  out  W  engine operand a, held from grant until next grant
- eng_b  out  W  engine operand b, held likewise
- eng_done  in  1  engine done
- eng_result  in  W  engine result
- eng_clear_n  out  1  active-low engine clear, low for exactly one cycle on abort

## Operation
- All outputs are registered. Reset values:
  - ack = 0, rsp_valid = 0, rsp_result = 0, rsp_error = 0, busy = 0
  - eng_start = 0, eng_a = 0, eng_b = 0, eng_clear_n = 1
  - state = IDLE, rr pointer = N-1, watchdog = 0
- States: IDLE, LAUNCH, WAIT, ABORT, RESP.
- IDLE:
  - When any req is high at an edge, grant the first requester after the rr pointer, searching upward with wrap; rr pointer becomes the granted index g.
  - At that edge: ack[g] = 1; latch eng_a/eng_b and internal copies; go to LAUNCH.
  - eng_start = 1 at the same edge only if both operands are nonzero.
- LAUNCH (1 cycle):
  - If a bypass applies, compute the result: a = 0 gives b; b = 0 gives a; both zero gives result 0 with rsp_error = 1. Go to RESP.
  - Otherwise clear the watchdog and go to WAIT.
- WAIT:
  - eng_done is sampled only in this state, so a stale done during LAUNCH is ignored.
  - eng_done = 1: capture eng_result into rsp_result with rsp_error = 0; go to RESP.
  - Otherwise increment the watchdog. When the watchdog = TIMEOUT-1 and done is low, go to ABORT.
  - Done in the same cycle as the timeout: done wins.
- ABORT (1 cycle): eng_clear_n = 0; rsp_result = 0, rsp_error = 1; go to RESP.
- RESP (1 cycle): rsp_valid[g] = 1; go to IDLE.
- Requests are never accepted outside IDLE. req from the granted requester after its ack starts a new transaction only through normal arbitration.
- Operands are taken from a_in/b_in at the grant edge only; later changes are ignored.
- Asynchronous reset in any state aborts the transaction silently, with no rsp_valid, and restores all reset values.

## Timing
- Edge E0 (IDLE, req sampled) → cycle 1: ack[g], eng_start, state LAUNCH.
- Engine path:
  - Cycle 2: WAIT.
  - Edge Ek with eng_done high → next cycle: rsp_valid[g], state RESP.
  - Next cycle: IDLE. The earliest new grant edge is Ek+2.
- Bypass path: cycle 1 ack, cycle 2 rsp_valid. Two cycles from grant to response; no eng_start.
- Timeout path: watchdog expiry after TIMEOUT WAIT cycles → 1 ABORT cycle → 1 RESP cycle.
- Fairness: with all N requesting continuously, grants rotate 0,1,…,N-1,0. A continuously requesting requester waits at most N-1 transactions.

## Test plan
- Single request: req[0] with a = 48, b = 18, engine model done after 6 cycles with result 6.
  - Required: ack[0] in cycle 1, eng_start exactly once.
  - Required: rsp_valid[0] with rsp_result = 6 and rsp_error = 0, one cycle after done is sampled.
- Round-robin: all four requesters request continuously after reset.
  - Required: grant order 0,1,2,3,0.
  - Required: each rsp_valid bit pulses only for the granted index, one transaction at a time.
- Bypass:
  - req[2] with a = 0, b = 35: rsp_result = 35, no eng_start, response in cycle 2.
  - a = 0, b = 0: rsp_result = 0, rsp_error = 1.
- Timeout: TIMEOUT = 8 and an engine that never asserts done.
  - Required: eng_clear_n low exactly one cycle after 8 WAIT cycles, then rsp_error = 1 and rsp_result = 0.
  - Then done and timeout in the same cycle: response carries eng_result with rsp_error = 0.
- Reset mid-operation: assert reset_n low during WAIT.
  - Required: all outputs at reset values immediately, no rsp_valid.
  - Required: rr pointer reset so that req[0] and req[3] both pending grants index 0 first.
- Stale done: hold eng_done high from the previous transaction into LAUNCH.
  - Required: done is not accepted before WAIT; the result is captured only from done sampled in WAIT.
